wb_cfg_slave: RTL
=================

WB_CFG_SLAVE -- requirements
Module: wb_cfg_slave

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the register-side response timeout in clock cycles (legal range 2..255).
REQ-002 clk  in  1  SHALL be the single clock; all logic is clocked on its rising edge.
REQ-003 rst_n  in  1  SHALL be the reset: synchronous and active-low.
REQ-004 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  SHALL be the Wishbone classic cycle, strobe and write-enable inputs.
REQ-005 wb_adr_i  in  32  SHALL be the byte address; wb_sel_i  in  4  byte selects; wb_dat_i  in  32  write data.
REQ-006 wb_dat_o  out  32, wb_ack_o  out  1, wb_err_o  out  1  SHALL be read data, acknowledge and error.
REQ-007 conf_base_i  in  32  SHALL be the WB_CONF_SPC_BAR value; only bits [31:12] are used.
REQ-008 reg_req_o  out  1, reg_we_o  out  1, reg_addr_o  out  12, reg_be_o  out  4, reg_wdata_o  out  32  SHALL form the register-file request.
REQ-009 reg_rdy_i  in  1, reg_rdata_i  in  32  SHALL form the register-file response.
REQ-010 busy_o  out  1  SHALL be high whenever the FSM is not IDLE.

Function
REQ-011 Hit SHALL be wb_cyc_i & wb_stb_i & (wb_adr_i[31:12] == conf_base_i[31:12]); a non-hit SHALL produce no ack, no err and no request.
REQ-012 Legal offsets SHALL be exactly the config_reg_addr_t members (0x000-0x03C, 0x100-0x168, 0x180-0x1F0, word steps).
REQ-013 FSM states SHALL be IDLE, REQ, ACK, ERR, DRAIN.
REQ-014 IDLE, hit with illegal offset, wb_adr_i[1:0] != 0 or wb_sel_i == 0 -> ERR; no reg_req_o is issued.
REQ-015 IDLE, legal write to VENDOR_DEVICE_ID or CLASS_REVISION -> ACK directly; write is discarded, no reg_req_o.
REQ-016 IDLE, other legal hit -> REQ; reg_addr_o, reg_we_o, reg_be_o, reg_wdata_o are captured and held stable for the whole of REQ.
REQ-017 reg_req_o SHALL be high in every REQ cycle; REQ with reg_rdy_i sampled high -> ACK, capturing reg_rdata_i for reads.
REQ-018 wb_ack_o SHALL be high for exactly the one ACK cycle, with wb_dat_o valid in that cycle; ACK -> IDLE.
REQ-019 wb_err_o SHALL be high for exactly the one ERR cycle; ERR -> IDLE.
REQ-020 Minimum latency: strobe sampled at edge 0, reg_req_o high in cycle 1; with reg_rdy_i high in cycle 1, wb_ack_o is high in cycle 2.
REQ-021 wb_cyc_i low during REQ SHALL move the FSM to DRAIN; DRAIN holds reg_req_o until reg_rdy_i, then -> IDLE with no ack or err.
REQ-022 wb_dat_o SHALL be zero outside ACK and after writes; wb_ack_o and wb_err_o SHALL never be high together.
REQ-023 A hit presented in the cycle ACK or ERR is asserted SHALL be ignored; it is accepted only once the FSM is in IDLE.

Reset
REQ-024 rst_n low at a clock edge SHALL force IDLE and clear all outputs, counter and captured fields to zero, including mid-transfer; no ack or err is emitted for an aborted transfer.

Configuration
REQ-025 With WB_CFG_TIMEOUT_EN defined, a counter SHALL count REQ/DRAIN cycles; reaching TIMEOUT_CYCLES without reg_rdy_i SHALL drop reg_req_o and go to ERR from REQ, or to IDLE from DRAIN.
REQ-026 Without WB_CFG_TIMEOUT_EN, no counter SHALL exist and REQ/DRAIN SHALL wait indefinitely for reg_rdy_i.

Structure
REQ-027 The shared package SHALL hold config_reg_addr_t, the FSM state enum wb_cfg_state_t, and the function cfg_addr_legal(offset).
REQ-028 Offset legality and read-only decode SHALL live in one combinational sub-module, wb_cfg_decode.

Verification
REQ-029 conf_base_i=0x2000_0000, read 0x2000_0184, reg_rdy_i high at cycle 1 with data 0xDEAD_BEEF -> reg_addr_o=0x184, ack at cycle 2, wb_dat_o=0xDEAD_BEEF.
REQ-030 Write 0x2000_01EC, data 0x0000_0005, sel 0x1, reg_rdy_i delayed 3 cycles -> reg_req_o held 4 cycles, reg_be_o=0x1, single ack.
REQ-031 Read 0x2000_0170 (hole), then 0x2000_0102 (misaligned) -> one-cycle err each, reg_req_o never asserted.
REQ-032 Write 0x2000_0000 -> ack in cycle 1, no reg_req_o; read 0x3000_0184 -> no response at all.
REQ-033 wb_cyc_i dropped in cycle 2 of REQ, reg_rdy_i at cycle 5 -> DRAIN, no ack or err, busy_o low at cycle 6; rst_n low mid-REQ -> all outputs zero the next cycle.
REQ-034 WB_CFG_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, reg_rdy_i held low -> reg_req_o drops and wb_err_o pulses after 16 REQ cycles.

Source files
------------

// File: rtl/wb_cfg_pkg.sv
// Shared types for the Wishbone configuration-space slave: register map,
// FSM state encoding and the offset legality helper.
package wb_cfg_pkg;

    // Every legal 12-bit configuration offset, word aligned.
    typedef enum logic [11:0] {
        VENDOR_DEVICE_ID = 12'h000, REG_004 = 12'h004, CLASS_REVISION = 12'h008, REG_00C = 12'h00C,
        REG_010 = 12'h010, REG_014 = 12'h014, REG_018 = 12'h018, REG_01C = 12'h01C,
        REG_020 = 12'h020, REG_024 = 12'h024, REG_028 = 12'h028, REG_02C = 12'h02C,
        REG_030 = 12'h030, REG_034 = 12'h034, REG_038 = 12'h038, REG_03C = 12'h03C,
        REG_100 = 12'h100, REG_104 = 12'h104, REG_108 = 12'h108, REG_10C = 12'h10C,
        REG_110 = 12'h110, REG_114 = 12'h114, REG_118 = 12'h118, REG_11C = 12'h11C,
        REG_120 = 12'h120, REG_124 = 12'h124, REG_128 = 12'h128, REG_12C = 12'h12C,
        REG_130 = 12'h130, REG_134 = 12'h134, REG_138 = 12'h138, REG_13C = 12'h13C,
        REG_140 = 12'h140, REG_144 = 12'h144, REG_148 = 12'h148, REG_14C = 12'h14C,
        REG_150 = 12'h150, REG_154 = 12'h154, REG_158 = 12'h158, REG_15C = 12'h15C,
        REG_160 = 12'h160, REG_164 = 12'h164, REG_168 = 12'h168,
        REG_180 = 12'h180, REG_184 = 12'h184, REG_188 = 12'h188, REG_18C = 12'h18C,
        REG_190 = 12'h190, REG_194 = 12'h194, REG_198 = 12'h198, REG_19C = 12'h19C,
        REG_1A0 = 12'h1A0, REG_1A4 = 12'h1A4, REG_1A8 = 12'h1A8, REG_1AC = 12'h1AC,
        REG_1B0 = 12'h1B0, REG_1B4 = 12'h1B4, REG_1B8 = 12'h1B8, REG_1BC = 12'h1BC,
        REG_1C0 = 12'h1C0, REG_1C4 = 12'h1C4, REG_1C8 = 12'h1C8, REG_1CC = 12'h1CC,
        REG_1D0 = 12'h1D0, REG_1D4 = 12'h1D4, REG_1D8 = 12'h1D8, REG_1DC = 12'h1DC,
        REG_1E0 = 12'h1E0, REG_1E4 = 12'h1E4, REG_1E8 = 12'h1E8, REG_1EC = 12'h1EC,
        REG_1F0 = 12'h1F0
    } config_reg_addr_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        ACK   = 3'd2,
        ERR   = 3'd3,
        DRAIN = 3'd4
    } wb_cfg_state_t;

    // True exactly for the members of config_reg_addr_t (three word-stepped windows).
    function automatic logic cfg_addr_legal(input logic [11:0] offset);
        logic aligned;
        aligned = (offset[1:0] == 2'b00);
        return aligned && ((offset <= 12'h03C) ||
                           (offset >= 12'h100 && offset <= 12'h168) ||
                           (offset >= 12'h180 && offset <= 12'h1F0));
    endfunction

endpackage

// File: rtl/wb_cfg_decode.sv
// Combinational offset decode: legality and read-only register detection.
module wb_cfg_decode
    import wb_cfg_pkg::*;
(
    input  logic [11:0] offset_i,
    output logic        legal_o,
    output logic        ro_o
);

    // Legal map lookup and read-only identification.
    always_comb begin
        legal_o = cfg_addr_legal(offset_i);
        ro_o    = (offset_i == VENDOR_DEVICE_ID) || (offset_i == CLASS_REVISION);
    end

endmodule

// File: rtl/wb_cfg_slave.sv
// Wishbone classic slave bridging the configuration-space window onto a
// simple register-file request/ready interface.
// Optional feature: define WB_CFG_TIMEOUT_EN to enable the REQ/DRAIN timeout.
module wb_cfg_slave
    import wb_cfg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    input  logic [31:0] conf_base_i,
    output logic        reg_req_o,
    output logic        reg_we_o,
    output logic [11:0] reg_addr_o,
    output logic [3:0]  reg_be_o,
    output logic [31:0] reg_wdata_o,
    input  logic        reg_rdy_i,
    input  logic [31:0] reg_rdata_i,
    output logic        busy_o
);

    wb_cfg_state_t state_q, state_d;
    logic [11:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;

    logic hit;
    logic legal;
    logic ro;
    logic bad_access;
    logic timeout;
    logic unused_base;

    wb_cfg_decode u_decode (
        .offset_i (wb_adr_i[11:0]),
        .legal_o  (legal),
        .ro_o     (ro)
    );

    // Window hit and access-level error qualification.
    always_comb begin
        unused_base = ^conf_base_i[11:0];
        hit         = wb_cyc_i && wb_stb_i && (wb_adr_i[31:12] == conf_base_i[31:12]);
        bad_access  = !legal || (wb_adr_i[1:0] != 2'b00) || (wb_sel_i == 4'h0);
    end

`ifdef WB_CFG_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;

    // Count cycles spent waiting on the register file; cleared everywhere else.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == REQ || state_q == DRAIN) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
        timeout = (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1)) && !reg_rdy_i;
    end

    // Timeout counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic [7:0] unused_tmo;

    // No counter: the timeout parameter is kept only for interface compatibility.
    always_comb begin
        unused_tmo = 8'(TIMEOUT_CYCLES);
        timeout    = 1'b0;
    end
`endif

    // Next-state and capture logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    if (bad_access) begin
                        state_d = ERR;
                    end else if (wb_we_i && ro) begin
                        state_d = ACK;
                        rdata_d = '0;
                    end else begin
                        state_d = REQ;
                        addr_d  = wb_adr_i[11:0];
                        we_d    = wb_we_i;
                        be_d    = wb_sel_i;
                        wdata_d = wb_dat_i;
                        rdata_d = '0;
                    end
                end
            end
            REQ: begin
                if (!wb_cyc_i) begin
                    state_d = (reg_rdy_i || timeout) ? IDLE : DRAIN;
                end else if (reg_rdy_i) begin
                    state_d = ACK;
                    if (!we_q) begin
                        rdata_d = reg_rdata_i;
                    end
                end else if (timeout) begin
                    state_d = ERR;
                end
            end
            DRAIN: begin
                if (reg_rdy_i || timeout) begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                state_d = IDLE;
                rdata_d = '0;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-field registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decoded from the current state and captured fields.
    always_comb begin
        wb_ack_o    = (state_q == ACK);
        wb_err_o    = (state_q == ERR);
        wb_dat_o    = (state_q == ACK) ? rdata_q : '0;
        reg_req_o   = (state_q == REQ) || (state_q == DRAIN);
        busy_o      = (state_q != IDLE);
        reg_addr_o  = addr_q;
        reg_we_o    = we_q;
        reg_be_o    = be_q;
        reg_wdata_o = wdata_q;
    end

endmodule
